// File: rtl/ifr_pkg.sv
// Shared definitions for the instruction-fetch responder: NOP encoding,
// FSM state encoding and wait-counter width.
package ifr_pkg;

  localparam logic [31:0] IFR_NOP   = 32'h00000013;
  localparam int          IFR_CNT_W = 4;

  typedef enum logic [1:0] {
    IFR_IDLE = 2'd0,
    IFR_WAIT = 2'd1,
    IFR_RESP = 2'd2
  } ifr_state_t;

endpackage

// File: rtl/ifr_store.sv
// Instruction store: DEPTH_WORDS x 32 array with one write port and one
// registered read port. A read and a write to the same word on the same edge
// return the old contents. Contents are never reset.
module ifr_store #(
  parameter int DEPTH_WORDS = 1024,
  localparam int AW = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Write port and registered read port (read-before-write on collisions)
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/instr_fetch_resp.sv
// Instruction-fetch responder. Accepts a fetch address, waits WAIT_STATES
// cycles, then returns the stored word with a one-cycle valid pulse; holds
// stall high while a fetch is outstanding. flush_in abandons any fetch.
// Optional feature macro: IFR_ALIGN_CHECK_EN (misaligned fetches answer NOP
// and raise ialign_err_out alongside instr_valid_out).
module instr_fetch_resp
  import ifr_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        ireq_in,
  input  logic [31:0] iaddr_in,
  input  logic        flush_in,
  input  logic        prog_we_in,
  input  logic [31:0] prog_addr_in,
  input  logic [31:0] prog_wdata_in,
  output logic [31:0] instr_out,
  output logic        instr_valid_out,
  output logic        stall_out,
  output logic        ialign_err_out
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [IFR_CNT_W-1:0] CNT_LAST =
    IFR_CNT_W'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);
  localparam ifr_state_t ACCEPT_NEXT = (WAIT_STATES > 0) ? IFR_WAIT : IFR_RESP;

  ifr_state_t           state_q, state_d;
  logic [IFR_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]          addr_q;
  logic [31:0]          last_q;
  logic                 accept;
  logic                 rd_en;
  logic [AW-1:0]        rd_idx;
  logic [31:0]          rd_data;
  logic                 prog_in_range;
  logic                 out_of_range;
  logic                 misaligned;
  logic                 resp_live;
  logic [31:0]          resp_word;
  logic                 unused_lsbs;

  // State register and wait counter
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IFR_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; flush beats everything, RESP may accept back-to-back
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    case (state_q)
      IFR_IDLE: begin
        if (ireq_in && !flush_in) begin
          accept  = 1'b1;
          state_d = ACCEPT_NEXT;
        end
      end
      IFR_WAIT: begin
        if (flush_in) begin
          state_d = IFR_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IFR_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IFR_RESP: begin
        if (ireq_in && !flush_in) begin
          accept  = 1'b1;
          state_d = ACCEPT_NEXT;
        end else begin
          state_d = IFR_IDLE;
        end
      end
      default: state_d = IFR_IDLE;
    endcase
  end

  // Fetch address latch (datapath, not reset)
  always_ff @(posedge clk_in) begin
    if (accept) addr_q <= iaddr_in;
  end

  // The store is read on the edge that enters RESP; with no wait states that
  // edge is the accept edge itself, so the live address is used.
  assign rd_en  = (state_d == IFR_RESP);
  assign rd_idx = (state_q == IFR_WAIT) ? addr_q[AW+1:2] : iaddr_in[AW+1:2];

  // Out-of-range program writes are dropped rather than aliased
  assign prog_in_range = ~|prog_addr_in[31:AW+2];

  ifr_store #(
    .DEPTH_WORDS(DEPTH_WORDS)
  ) u_store (
    .clk   (clk_in),
    .we    (prog_we_in && prog_in_range),
    .waddr (prog_addr_in[AW+1:2]),
    .wdata (prog_wdata_in),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (rd_data)
  );

  assign out_of_range = |addr_q[31:AW+2];

`ifdef IFR_ALIGN_CHECK_EN
  assign misaligned  = |addr_q[1:0];
  assign unused_lsbs = ^prog_addr_in[1:0];
`else
  assign misaligned  = 1'b0;
  assign unused_lsbs = ^{addr_q[1:0], prog_addr_in[1:0]};
`endif

  assign resp_live = (state_q == IFR_RESP) && !flush_in;
  assign resp_word = (out_of_range || misaligned) ? IFR_NOP : rd_data;

  // Last delivered instruction, held between responses
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) last_q <= IFR_NOP;
    else if (resp_live) last_q <= resp_word;
  end

  assign instr_out       = resp_live ? resp_word : last_q;
  assign instr_valid_out = resp_live;
  assign ialign_err_out  = resp_live && misaligned;
  assign stall_out       = (state_q == IFR_WAIT) ||
                           (ireq_in && !accept && (state_q != IFR_WAIT));

endmodule

// File: tb/tb_instr_fetch_resp.sv
// Bench for instr_fetch_resp: three instances with WAIT_STATES 1, 0 and 3
// share the clock, reset and program-load port. Responses are checked
// against a scoreboard of expected {instance, cycle, word, align error}.
module tb_instr_fetch_resp;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk, rst;
  logic        ireq  [3];
  logic [31:0] iaddr [3];
  logic        flush [3];
  logic        prog_we;
  logic [31:0] prog_addr, prog_wdata;
  logic [31:0] instr [3];
  logic        valid [3];
  logic        stall [3];
  logic        aerr  [3];

  instr_fetch_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_d0 (
    .clk_in(clk), .rst_in(rst), .ireq_in(ireq[0]), .iaddr_in(iaddr[0]), .flush_in(flush[0]),
    .prog_we_in(prog_we), .prog_addr_in(prog_addr), .prog_wdata_in(prog_wdata),
    .instr_out(instr[0]), .instr_valid_out(valid[0]), .stall_out(stall[0]), .ialign_err_out(aerr[0]));
  instr_fetch_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_d1 (
    .clk_in(clk), .rst_in(rst), .ireq_in(ireq[1]), .iaddr_in(iaddr[1]), .flush_in(flush[1]),
    .prog_we_in(prog_we), .prog_addr_in(prog_addr), .prog_wdata_in(prog_wdata),
    .instr_out(instr[1]), .instr_valid_out(valid[1]), .stall_out(stall[1]), .ialign_err_out(aerr[1]));
  instr_fetch_resp #(.DEPTH_WORDS(1024), .WAIT_STATES(3)) u_d2 (
    .clk_in(clk), .rst_in(rst), .ireq_in(ireq[2]), .iaddr_in(iaddr[2]), .flush_in(flush[2]),
    .prog_we_in(prog_we), .prog_addr_in(prog_addr), .prog_wdata_in(prog_wdata),
    .instr_out(instr[2]), .instr_valid_out(valid[2]), .stall_out(stall[2]), .ialign_err_out(aerr[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          dut;
    int          due;
    logic [31:0] data;
    logic        err;
  } exp_t;

  typedef struct {
    int          dut;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } vec_t;

  exp_t        sb[$];
  vec_t        vt[9];
  int          ws[3];
  int          nvec, nerr, cyc;
  logic [31:0] img [1024];
  logic [31:0] smp_instr [3];
  logic        smp_valid [3];
  logic        smp_stall [3];
  logic [31:0] held;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_word(input logic [31:0] a);
`ifdef IFR_ALIGN_CHECK_EN
    if (a[1:0] != 2'b00) return NOP;
`endif
    if (a[31:12] != 20'd0) return NOP;
    return img[a[11:2]];
  endfunction

  function automatic logic exp_err(input logic [31:0] a);
`ifdef IFR_ALIGN_CHECK_EN
    return (a[1:0] != 2'b00);
`else
    return (a == 32'hFFFF_FFFF);
`endif
  endfunction

  task automatic expect_resp(input int d, input int due, input logic [31:0] a);
    exp_t e;
    e.dut = d; e.due = due; e.data = exp_word(a); e.err = exp_err(a);
    sb.push_back(e);
  endtask

  // One clock period: sample and score at negedge, then advance past posedge
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      smp_instr[d] = instr[d];
      smp_valid[d] = valid[d];
      smp_stall[d] = stall[d];
      if (aerr[d] && !valid[d]) begin
        nvec++; nerr++;
        $display("FAIL aerr_without_valid dut%0d: got 1 expected 0", d);
      end
      if (valid[d]) begin
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_valid dut%0d: got instr %h, expected no response (cycle %0d)", d, instr[d], cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_dut", 32'(d), 32'(e.dut));
          chk("resp_cycle", 32'(cyc), 32'(e.due));
          chk("resp_instr", instr[d], e.data);
          chk("resp_aerr", 32'(aerr[d]), 32'(e.err));
        end
      end
    end
    if (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      nvec++; nerr++;
      $display("FAIL missing_valid dut%0d: got no response, expected %h at cycle %0d", e.dut, e.data, e.due);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic prog_load(input int w, input logic [31:0] v);
    prog_we = 1'b1; prog_addr = 32'(w) << 2; prog_wdata = v;
    cycle();
    prog_we = 1'b0;
    img[w] = v;
  endtask

  initial begin
    nvec = 0; nerr = 0; cyc = 0;
    ws[0] = 1; ws[1] = 0; ws[2] = 3;
    rst = 1'b1; prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    for (int d = 0; d < 3; d++) begin
      ireq[d] = 1'b0; iaddr[d] = '0; flush[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: quiet after reset
    for (int i = 0; i < 10; i++) begin
      cycle();
      chk("rst_instr", smp_instr[0], NOP);
      chk("rst_valid", 32'(smp_valid[0]), 32'd0);
      chk("rst_stall", 32'(smp_stall[0]), 32'd0);
    end

    // program image
    for (int w = 0; w < 16; w++) prog_load(w, 32'hA500_0000 ^ (32'(w) * 32'h0101_0101));
    prog_load(5, 32'h00500093);
    prog_load(1023, 32'hDEAD_BEEF);

    // 2: single fetch with one wait state, stall profile
    ireq[0] = 1'b1; iaddr[0] = 32'h14;
    expect_resp(0, cyc + 2, 32'h14);
    cycle(); chk("t2_stall_accept", 32'(smp_stall[0]), 32'd0);
    ireq[0] = 1'b0;
    cycle(); chk("t2_stall_wait", 32'(smp_stall[0]), 32'd1);
    cycle(); chk("t2_stall_resp", 32'(smp_stall[0]), 32'd0);
    chk("t2_instr", smp_instr[0], 32'h00500093);
    cycle(); chk("t2_instr_hold", smp_instr[0], 32'h00500093);

    // table-driven single fetches across instances and address classes
    vt[0] = '{0, 32'h0000_0014, 32'h0, 1'b0};
    vt[1] = '{0, 32'h0000_0000, 32'h0, 1'b0};
    vt[2] = '{0, 32'h0000_1000, 32'h0, 1'b0};
    vt[3] = '{0, 32'h0000_0FFC, 32'h0, 1'b0};
    vt[4] = '{0, 32'h0000_0006, 32'h0, 1'b0};
    vt[5] = '{0, 32'hFFFF_FFFC, 32'h0, 1'b0};
    vt[6] = '{1, 32'h0000_003C, 32'h0, 1'b0};
    vt[7] = '{2, 32'h0000_0020, 32'h0, 1'b0};
    vt[8] = '{1, 32'h0000_0007, 32'h0, 1'b0};
    for (int i = 0; i < 9; i++) begin
      vt[i].data = exp_word(vt[i].addr);
      vt[i].err  = exp_err(vt[i].addr);
    end
    for (int i = 0; i < 9; i++) begin
      ireq[vt[i].dut] = 1'b1; iaddr[vt[i].dut] = vt[i].addr;
      expect_resp(vt[i].dut, cyc + ws[vt[i].dut] + 1, vt[i].addr);
      cycle();
      ireq[vt[i].dut] = 1'b0;
      repeat (ws[vt[i].dut] + 2) cycle();
      chk("vec_instr_hold", instr[vt[i].dut], vt[i].data);
    end

    // 3: back-to-back with no wait states
    for (int i = 0; i < 3; i++) begin
      ireq[1] = 1'b1; iaddr[1] = 32'(i) << 2;
      expect_resp(1, cyc + 1, 32'(i) << 2);
      cycle();
      chk("t3_stall", 32'(smp_stall[1]), 32'd0);
    end
    ireq[1] = 1'b0;
    cycle();
    chk("t3_last", smp_instr[1], img[2]);
    cycle();

    // flush during the response cycle: no pulse, output held
    held = instr[1];
    ireq[1] = 1'b1; iaddr[1] = 32'h4;
    cycle();
    ireq[1] = 1'b0; flush[1] = 1'b1;
    cycle();
    chk("resp_flush_valid", 32'(smp_valid[1]), 32'd0);
    chk("resp_flush_instr", smp_instr[1], held);
    flush[1] = 1'b0;
    cycle(); chk("resp_flush_after", smp_instr[1], held);

    // flush together with request in IDLE: not accepted
    ireq[0] = 1'b1; flush[0] = 1'b1; iaddr[0] = 32'h14;
    cycle(); chk("idle_flush_stall", 32'(smp_stall[0]), 32'd1);
    ireq[0] = 1'b0; flush[0] = 1'b0;
    repeat (3) begin
      cycle(); chk("idle_flush_nostall", 32'(smp_stall[0]), 32'd0);
    end

    // 4: three wait states, flush in the 2nd wait cycle
    ireq[2] = 1'b1; iaddr[2] = 32'h14;
    expect_resp(2, cyc + 4, 32'h14);
    cycle(); ireq[2] = 1'b0;
    repeat (5) cycle();
    held = instr[2];
    ireq[2] = 1'b1; iaddr[2] = 32'h10;
    cycle(); ireq[2] = 1'b0;
    cycle(); chk("t4_stall_w1", 32'(smp_stall[2]), 32'd1);
    flush[2] = 1'b1;
    cycle(); chk("t4_stall_w2", 32'(smp_stall[2]), 32'd1);
    flush[2] = 1'b0;
    cycle(); chk("t4_idle_stall", 32'(smp_stall[2]), 32'd0);
    chk("t4_instr", smp_instr[2], held);
    repeat (3) cycle();
    chk("t4_instr_late", instr[2], held);

    // read-before-write on the RESP entry edge
    ireq[0] = 1'b1; iaddr[0] = 32'h8;
    expect_resp(0, cyc + 2, 32'h8);
    cycle(); ireq[0] = 1'b0;
    prog_we = 1'b1; prog_addr = 32'h8; prog_wdata = 32'h1234_5678;
    cycle(); prog_we = 1'b0;
    cycle(); img[2] = 32'h1234_5678;
    ireq[0] = 1'b1; iaddr[0] = 32'h8;
    expect_resp(0, cyc + 2, 32'h8);
    cycle(); ireq[0] = 1'b0;
    repeat (3) cycle();

    // asynchronous reset mid-fetch drops it
    ireq[2] = 1'b1; iaddr[2] = 32'h20;
    cycle(); ireq[2] = 1'b0;
    cycle();
    #2 rst = 1'b1;
    #2;
    chk("rst_mid_stall", 32'(stall[2]), 32'd0);
    chk("rst_mid_instr", instr[2], NOP);
    cycle();
    rst = 1'b0;
    repeat (6) cycle();
    chk("rst_mid_after", instr[2], NOP);

    if (sb.size() != 0) begin
      nvec++; nerr++;
      $display("FAIL sb_drain: got %0d outstanding responses expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
